// File: rtl/fifo_ram_ctrl_if.sv
// Stream-in / stream-out handshake and dual-port memory bus of fifo_ram_ctrl.
//   in_data/in_valid/in_ready     : upstream valid/ready stream
//   out_data/out_valid/out_ready  : downstream valid/ready stream
//   mem_wr_addr/mem_wr_data/mem_wr_en : memory write port (port1)
//   mem_rd_addr/mem_rd_data       : memory read port (port2), one-cycle read latency
//   level                         : entries held by the controller
// Modport master is the controller's view, slave is the surrounding environment.
interface fifo_ram_ctrl_if #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [ADDR_WIDTH+1:0] level;

    modport master (
        input  in_data, in_valid, out_ready, mem_rd_data,
        output in_ready, out_data, out_valid, mem_wr_addr, mem_wr_data, mem_wr_en,
               mem_rd_addr, level
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_rd_data,
        input  in_ready, out_data, out_valid, mem_wr_addr, mem_wr_data, mem_wr_en,
               mem_rd_addr, level
    );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller around an external dual-port RAM with one-cycle read latency.
// Words are written straight into the RAM on accept; the read side prefetches into a
// 2-entry output buffer so the downstream sees one word per cycle when not stalled.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_ram_ctrl_if.master (streams, memory ports, level)
module fifo_ram_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 6
) (
    input logic             clk,
    input logic             rst_n,
    fifo_ram_ctrl_if.master bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;

    logic       in_ready;
    logic       out_valid;
    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] pending;

    always_comb begin
        in_ready  = (mem_count < (ADDR_WIDTH + 1)'(DEPTH));
        // Gated with rst_n so nothing reaches the RAM while reset is held.
        push      = bus.in_valid && in_ready && rst_n;
        out_valid = (buf_count != 2'd0);
        pop       = out_valid && bus.out_ready;
        // Buffer slots that will be occupied once the current read lands.
        pending   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        rd_issue  = (mem_count != '0) && (pending < 3'd2);
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = buf_head;
    assign bus.mem_wr_en   = push;
    assign bus.mem_wr_addr = wr_ptr;
    assign bus.mem_wr_data = bus.in_data;
    assign bus.mem_rd_addr = rd_ptr;
    assign bus.level       = {1'b0, mem_count}
                           + {(ADDR_WIDTH + 1)'(0), inflight}
                           + {ADDR_WIDTH'(0), buf_count};

    // Write pointer, read pointer and RAM occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, rd_issue})
                2'b10:   mem_count <= mem_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   mem_count <= mem_count - (ADDR_WIDTH + 1)'(1);
                default: mem_count <= mem_count;
            endcase
            inflight <= rd_issue;
        end
    end

    // Output buffer: buf_head is the word on out_data, buf_tail the one behind it.
    // buf_count + inflight never exceeds 2, so a landing read always has a free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_count <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
        end else begin
            if (inflight) begin
                if (pop) begin
                    if (buf_count == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= bus.mem_rd_data;
                    end else begin
                        buf_head <= bus.mem_rd_data;
                    end
                end else if (buf_count == 2'd0) begin
                    buf_head <= bus.mem_rd_data;
                end else begin
                    buf_tail <= bus.mem_rd_data;
                end
            end else if (pop) begin
                buf_head <= buf_tail;
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: payload width, matching the dual-port memory data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: memory address width; DEPTH = 2^ADDR_WIDTH = 64 entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, DATA_WIDTH: upstream payload.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, DATA_WIDTH: downstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes out_data this cycle.
REQ-011 SHALL have port mem_wr_addr, output, ADDR_WIDTH: drives memory port1_addr.
REQ-012 SHALL have port mem_wr_data, output, DATA_WIDTH: drives memory port1_data_in.
REQ-013 SHALL have port mem_wr_en, output, 1 bit: drives memory port1_write_en.
REQ-014 SHALL have port mem_rd_addr, output, ADDR_WIDTH: drives memory port2_addr; port2_write_en is tied 0 by the integrator.
REQ-015 SHALL have port mem_rd_data, input, DATA_WIDTH: from memory port2_data_out; valid the cycle after mem_rd_addr is presented.
REQ-016 SHALL have port level, output, ADDR_WIDTH+2: total entries held (memory + in-flight + output buffer).

Function
REQ-017 SHALL accept a word on cycles where in_valid && in_ready, driving mem_wr_en=1, mem_wr_addr=wr_ptr, mem_wr_data=in_data combinationally that cycle, then increment wr_ptr modulo DEPTH.
REQ-018 SHALL drive in_ready = (mem_count < DEPTH), from registered state only; mem_count is ADDR_WIDTH+1 bits.
REQ-019 SHALL issue a memory read (rd_issue) in a cycle when mem_count > 0 and (buf_count + inflight − pop) < 2; mem_rd_addr = rd_ptr at all times; rd_ptr increments modulo DEPTH on rd_issue.
REQ-020 SHALL set inflight on rd_issue and, in the following cycle, write mem_rd_data into the 2-entry output buffer (FIFO order).
REQ-021 SHALL present the buffer head on out_data with out_valid = (buf_count > 0); pop = out_valid && out_ready.
REQ-022 SHALL hold out_data stable while out_valid && !out_ready.
REQ-023 SHALL update mem_count by +push −rd_issue per cycle; simultaneous push and rd_issue leave it unchanged.
REQ-024 SHALL compute level = mem_count + inflight + buf_count; maximum DEPTH+2.
REQ-025 SHALL never read an address in the same cycle it is first written (guaranteed because rd_issue depends on registered mem_count).
REQ-026 SHALL give latency of 3 cycles: word pushed in cycle t into an empty block gives out_valid=1 in cycle t+3.
REQ-027 SHALL sustain one word per cycle in steady state when out_ready is held high.
REQ-028 SHALL wrap wr_ptr and rd_ptr from DEPTH−1 to 0 with no gap or duplicate.
REQ-029 SHALL ignore in_data when in_valid=0 or in_ready=0 (no write, no pointer change).

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear wr_ptr, rd_ptr, mem_count, inflight and buf_count to 0.
REQ-031 SHALL hold out_valid=0, in_ready=1, mem_wr_en=0, level=0 and mem_rd_addr=0 while in reset; out_data is 0.
REQ-032 SHALL, on reset mid-operation, discard all stored and in-flight words; the first push after release lands at address 0.

Verification
REQ-033 SHALL cover single word: push 0x1A5 at cycle 0, out_ready=1 -> out_valid at cycle 3, out_data=0x1A5, level returns to 0 at cycle 4.
REQ-034 SHALL cover fill: out_ready=0, push 66 words 0..65 -> in_ready drops after 66th accept, level=66, mem_wr_en never asserted while in_ready=0.
REQ-035 SHALL cover stream: continuous push with out_ready=1 for 200 words -> output sequence identical, one word/cycle after 3-cycle latency, pointers wrap 3 times.
REQ-036 SHALL cover backpressure: random out_ready at 50% with random in_valid -> no loss, no duplication, out_data stable while stalled.
REQ-037 SHALL cover reset mid-stream: assert rst_n=0 with level=10 -> out_valid=0 and level=0 immediately; next push 0x3FFF appears as first output.
